// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and sizing helpers for the digit-serial adder.
// Optional subtract mode in the top is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit steps needed to cover the full operand width.
    function automatic int num_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Step counter width; a single-step build still gets a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        if (n > 32'sd1) begin
            return $clog2(n);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// fa_digit: DIGIT-wide ripple of gate-level full adders. Purely combinational.
// Also exposes the carry into the most significant bit so the caller can
// derive signed overflow.
module fa_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c_s;

    assign c_s[0] = ci;

    genvar i;
    generate
        for (i = 0; i < DIGIT; i = i + 1) begin : g_fa
            assign s[i]     = a[i] ^ b[i] ^ c_s[i];
            assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co    = c_s[DIGIT];
    assign c_msb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: computes a + b + c_in over WIDTH/DIGIT cycles using one
// DIGIT-wide ripple slice, with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b - c_in mode).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NUM_STEPS = num_steps(WIDTH, DIGIT);
    localparam int CNT_W     = cnt_width(WIDTH, DIGIT);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic              c_out_r;
    logic              ovf_r;
    logic              out_valid_r;

    logic [DIGIT-1:0]  a_dig_s;
    logic [DIGIT-1:0]  b_dig_s;
    logic [DIGIT-1:0]  s_dig_s;
    logic              co_s;
    logic              c_msb_s;
    logic              last_s;
    logic              init_carry_s;
    logic [WIDTH-1:0]  sum_next_s;

`ifdef SERIAL_ADDER_SUB_EN
    logic              sub_r;
`endif

    // Slice operands: low digit of each shift register, B optionally inverted for subtract.
    always_comb begin
        a_dig_s = a_r[DIGIT-1:0];
`ifdef SERIAL_ADDER_SUB_EN
        b_dig_s      = b_r[DIGIT-1:0] ^ {DIGIT{sub_r}};
        init_carry_s = c_in ^ sub;
`else
        b_dig_s      = b_r[DIGIT-1:0];
        init_carry_s = c_in;
`endif
        last_s = (cnt_r == CNT_W'(NUM_STEPS - 1));
    end

    fa_digit #(
        .DIGIT (DIGIT)
    ) u_fa_digit (
        .a     (a_dig_s),
        .b     (b_dig_s),
        .ci    (carry_r),
        .s     (s_dig_s),
        .co    (co_s),
        .c_msb (c_msb_s)
    );

    // The new slice sum enters at the top; after NUM_STEPS shifts it lines up.
    generate
        if (DIGIT == WIDTH) begin : g_sum_full
            assign sum_next_s = s_dig_s;
        end else begin : g_sum_shift
            assign sum_next_s = {s_dig_s, sum_r[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Control FSM and datapath registers: capture, step the slice, hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= init_carry_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_r   <= sub;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    sum_r   <= sum_next_s;
                    carry_r <= co_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        c_out_r     <= co_s;
                        ovf_r       <= c_msb_s ^ co_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, scoreboard-based bench for serial_adder.
// Two instances: WIDTH=8/DIGIT=1 and WIDTH=8/DIGIT=4, sharing operand inputs.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       c_out;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       dsel;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       sub;
    logic       out_ready;

    logic       iv0, iv1;
    logic       ir0, ir1, ov0, ov1, co0, co1, of0, of1;
    logic [7:0] s0, s1;

    logic       cur_ir, cur_ov, cur_co, cur_of;
    logic [7:0] cur_s;

    int   checks;
    int   passed;
    int   fails;
    exp_t q[$];

    assign iv0 = in_valid & ~dsel;
    assign iv1 = in_valid & dsel;

    assign cur_ir = dsel ? ir1 : ir0;
    assign cur_ov = dsel ? ov1 : ov0;
    assign cur_co = dsel ? co1 : co0;
    assign cur_of = dsel ? of1 : of0;
    assign cur_s  = dsel ? s1  : s0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov0), .out_ready(out_ready),
        .sum(s0), .c_out(co0), .ovf(of0)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov1), .out_ready(out_ready),
        .sum(s1), .c_out(co1), .ovf(of1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width add with B/carry inverted for subtract, overflow from
    // the carry into bit 7 versus the carry out of bit 7.
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic ci, input logic sb);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] full;
        logic [7:0] low;
        exp_t       e;
        bb   = sb ? ~bv : bv;
        cc   = sb ? ~ci : ci;
        full = {1'b0, av} + {1'b0, bb} + {8'd0, cc};
        low  = {1'b0, av[6:0]} + {1'b0, bb[6:0]} + {7'd0, cc};
        e.sum   = full[7:0];
        e.c_out = full[8];
        e.ovf   = low[7] ^ full[8];
        return e;
    endfunction

    task automatic op(input logic d, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic sb, input int hold, input int lat);
        int         cyc;
        logic [7:0] snap;
        exp_t       e;
        dsel     = d;
        a        = av;
        b        = bv;
        c_in     = ci;
        sub      = sb;
        in_valid = 1'b1;
        #1;
        chk("in_ready_before", {31'd0, cur_ir}, 32'd1);
        q.push_back(model(av, bv, ci, sb));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'hA5;
        b        = 8'h5A;
        cyc = 0;
        while (!cur_ov && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        snap = cur_s;
        for (int i = 0; i < hold; i++) begin
            a        = ~av;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_sum_stable", {24'd0, cur_s}, {24'd0, snap});
            chk("bp_in_ready", {31'd0, cur_ir}, 32'd0);
            chk("bp_out_valid", {31'd0, cur_ov}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = q.pop_front();
        chk("sum", {24'd0, cur_s}, {24'd0, e.sum});
        chk("c_out", {31'd0, cur_co}, {31'd0, e.c_out});
        chk("ovf", {31'd0, cur_of}, {31'd0, e.ovf});
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after", {31'd0, cur_ir}, 32'd1);
        chk("out_valid_after", {31'd0, cur_ov}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dsel      = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on both instances.
        chk("rst_in_ready0", {31'd0, ir0}, 32'd1);
        chk("rst_out_valid0", {31'd0, ov0}, 32'd0);
        chk("rst_sum0", {24'd0, s0}, 32'd0);
        chk("rst_c_out0", {31'd0, co0}, 32'd0);
        chk("rst_ovf0", {31'd0, of0}, 32'd0);
        chk("rst_in_ready1", {31'd0, ir1}, 32'd1);
        chk("rst_out_valid1", {31'd0, ov1}, 32'd0);
        chk("rst_sum1", {24'd0, s1}, 32'd0);

        // Carry wrap, signed overflow, and the 4-bit-digit instance.
        op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8);
        op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 8);
        op(1'b1, 8'h3C, 8'h55, 1'b1, 1'b0, 0, 2);
        op(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0, 0, 2);
        op(1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 0, 8);

        // Backpressure for 10 cycles with competing operands offered.
        op(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 10, 8);

        // Reset in the middle of RUN: operation discarded, no output.
        dsel     = 1'b0;
        a        = 8'h11;
        b        = 8'h22;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, ir0}, 32'd1);
        chk("midrst_out_valid", {31'd0, ov0}, 32'd0);
        chk("midrst_sum", {24'd0, s0}, 32'd0);
        op(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 0, 8);

`ifdef SERIAL_ADDER_SUB_EN
        op(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 0, 8);
        op(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 0, 8);
        op(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 0, 2);
`endif

        chk("scoreboard_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised adder that computes `a + b + c_in` over `WIDTH/DIGIT` clock cycles, processing `DIGIT` bits per cycle through one small ripple slice. It generalises the single-bit gate-level full adder into a width-configurable, area-lean arithmetic unit. The unit sits between operand producers and result consumers using valid/ready handshakes, and reports carry-out and signed overflow.

## Interface
- `WIDTH`, 8, operand/result width in bits; must be a multiple of `DIGIT`
- `DIGIT`, 1, bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`
- `clk` in 1: the block's only clock
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: operands present
- `in_ready` out 1: unit can accept operands
- `a` in `WIDTH`: operand A
- `b` in `WIDTH`: operand B
- `c_in` in 1: carry-in; borrow-in when `sub`=1
- `sub` in 1: subtract mode; present only with `SERIAL_ADDER_SUB_EN`
- `out_valid` out 1: result present
- `out_ready` in 1: consumer accepts result
- `sum` out `WIDTH`: result
- `c_out` out 1: carry out of the MSB; for subtraction, 1 means no borrow
- `ovf` out 1: signed overflow, equal to the carry into the MSB XOR the carry out of the MSB

## Operation
- The FSM has three states: IDLE, RUN and DONE. `NUM_STEPS = WIDTH/DIGIT`.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` && `in_ready`: latch `a` and `b` (and `sub`) into shift registers, set carry register to `c_in`, clear the step counter, go to RUN.
- **RUN**
  - Each cycle, the slice adds the low `DIGIT` bits of the A and B registers plus the carry.
  - The A and B registers shift right by `DIGIT`.
  - The slice sum shifts into the top of the sum register.
  - The slice carry-out updates the carry register. The carry into the slice MSB is also registered, for `ovf`.
  - The counter increments. After step `NUM_STEPS-1`, go to DONE.
- **DONE**
  - `out_valid`=1; `sum`, `c_out` and `ovf` are stable.
  - On `out_ready`, go to IDLE.
- `in_ready`=0 in RUN and DONE. Inputs are ignored there, and `a`/`b` changes have no effect after capture.
- Arithmetic is modulo 2^`WIDTH`; `c_out` is bit `WIDTH` of the full sum.
- Reset (any state, including mid-RUN) forces IDLE. It clears the step counter, the carry register, the sum register and the flags. The in-progress operation is discarded with no output.

## Timing
- Reset values:
  - `in_ready`=1
  - `out_valid`=0
  - `sum`=0
  - `c_out`=0
  - `ovf`=0
- Latency: acceptance at edge N gives `out_valid`=1 after edge N+`NUM_STEPS`, so `NUM_STEPS` cycles in RUN.
- The result is held indefinitely while `out_ready`=0.
- `in_ready` reasserts the cycle after the `out_valid`/`out_ready` handshake. There is no overlap of consecutive operations; throughput is one result per `NUM_STEPS`+2 cycles minimum.
- `out_ready` asserted in IDLE or RUN is ignored.
- Outputs are registered only; no combinational input-to-output path exists other than `in_ready` from state.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - The `sub` port exists and is latched at capture.
  - When `sub`=1, the B bits are inverted before the slice and the initial carry is `~c_in`, giving `a - b - c_in`.
  - `c_out`=1 means no borrow; `ovf` is signed subtraction overflow.
- Undefined: there is no `sub` port; the unit adds only.

## Structure
- Package `serial_adder_pkg` holds:
  - the state enum typedef (IDLE/RUN/DONE)
  - a function returning `NUM_STEPS` and the counter width `$clog2(NUM_STEPS)`, min 1
- Sub-module `fa_digit`:
  - a `DIGIT`-wide ripple of gate-level full adders (XOR/AND/OR)
  - purely combinational, instantiated once
  - outputs: digit sum, carry out, and carry into its MSB

## Test plan
- `WIDTH`=8, `DIGIT`=1: `a`=0xFF, `b`=0x01, `c_in`=0 → `sum`=0x00, `c_out`=1, `ovf`=0; `out_valid` 8 cycles after acceptance.
- `WIDTH`=8, `DIGIT`=1: `a`=0x7F, `b`=0x01, `c_in`=0 → `sum`=0x80, `c_out`=0, `ovf`=1.
- `WIDTH`=8, `DIGIT`=4: `a`=0x3C, `b`=0x55, `c_in`=1 → `sum`=0x92, `c_out`=0, `ovf`=1; `out_valid` 2 cycles after acceptance.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. `sum` is stable, `in_ready` stays 0, and new operands are not accepted. Set `out_ready`=1: `in_ready`=1 next cycle.
- Reset mid-RUN: assert `rst` at step 3 of 8. Next cycle: `in_ready`=1, `out_valid`=0, `sum`=0. A following operation 0x10+0x20 gives 0x30.
- With `SERIAL_ADDER_SUB_EN`: `sub`=1, `a`=0x05, `b`=0x07, `c_in`=0 → `sum`=0xFE, `c_out`=0, `ovf`=0. Then `a`=0x80, `b`=0x01 → `sum`=0x7F, `c_out`=1, `ovf`=1.
